conv2d_ctrl: RTL and testbench

//  Sequencer for the pipelined 3x3 conv2d kernel. Walks an HxW map (stride 1, no padding) in raster order.

---
 rtl/conv2d_ctrl_pkg.sv | 26 ++
 rtl/conv2d_result_fifo.sv | 51 +++++
 rtl/conv2d_ctrl.sv | 165 ++++++++++++++++
 tb/tb_conv2d_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv2d_ctrl_pkg.sv
// Shared definitions for the conv2d sequencer: widths, depths, FSM states and
// the result FIFO entry layout.
package conv2d_ctrl_pkg;

   localparam int BIT_DATA       = 8;
   localparam int KSIZE          = 9;
   localparam int BIT_Y          = 2 * BIT_DATA + $clog2(KSIZE - 1);
   localparam int KERNEL_LATENCY = 5;
   localparam int DIM_BITS       = 8;
   localparam int FIFO_DEPTH     = 8;
   localparam int CNT_BITS       = $clog2(FIFO_DEPTH + 1);
   localparam int SEQ_BITS       = 2 * DIM_BITS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef struct packed {
      logic             last;
      logic [BIT_Y-1:0] data;
   } result_t;

endpackage

// File: rtl/conv2d_result_fifo.sv
// Synchronous result FIFO holding kernel y plus its end-of-map flag.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module conv2d_result_fifo
   import conv2d_ctrl_pkg::*;
(
   input  logic    clock,
   input  logic    reset,
   input  logic    push,
   input  result_t push_data,
   input  logic    pop,
   output logic    empty,
   output result_t pop_data
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        full;
   result_t     mem_q [FIFO_DEPTH];

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
   end

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   // Gate the read port so stale or never-written entries never reach the outputs.
   assign pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is deliberately not reset; clearing the pointers empties the FIFO.
   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

   no_overflow: assert property (@(posedge clock) disable iff (reset) (push && !pop) |-> !full);
   no_underrun: assert property (@(posedge clock) disable iff (reset) pop |-> !empty);

endmodule

// File: rtl/conv2d_ctrl.sv
// Sequencer for the pipelined 3x3 conv2d kernel: raster window requests,
// kernel token delay line, credit-limited capture of results into a FIFO.
module conv2d_ctrl
   import conv2d_ctrl_pkg::*;
(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic [DIM_BITS-1:0]     cfg_height,
   input  logic [DIM_BITS-1:0]     cfg_width,
   output logic                    busy,
   output logic                    done,
   output logic                    cfg_err,
   output logic                    win_valid,
   input  logic                    win_ready,
   output logic [DIM_BITS-1:0]     win_row,
   output logic [DIM_BITS-1:0]     win_col,
   input  logic                    kernel_x_valid,
   input  logic signed [BIT_Y-1:0] kernel_y,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [BIT_Y-1:0] out_data,
   output logic                    out_last
);

   localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
   localparam logic [DIM_BITS-1:0] DIM_ONE = DIM_BITS'(1);

   state_e                    state_q, state_d;
   logic [DIM_BITS-1:0]       oh_q, oh_d, ow_q, ow_d;
   logic [DIM_BITS-1:0]       row_q, row_d, col_q, col_d;
   logic [CNT_BITS-1:0]       outst_q, outst_d;
   logic [CNT_BITS-1:0]       pend_q, pend_d;
   logic [KERNEL_LATENCY-1:0] tok_q, tok_d;
   logic [SEQ_BITS-1:0]       push_cnt_q, push_cnt_d;
   logic [SEQ_BITS-1:0]       last_idx_q, last_idx_d;
   logic                      cfg_err_q, cfg_err_d;

   logic                cfg_ok, win_hs, pop, push, fifo_empty;
   logic [DIM_BITS-1:0] oh_new, ow_new;
   result_t             push_entry, head_entry;

   assign cfg_ok    = (cfg_height >= DIM_BITS'(3)) && (cfg_width >= DIM_BITS'(3));
   assign oh_new    = cfg_height - DIM_BITS'(2);
   assign ow_new    = cfg_width  - DIM_BITS'(2);
   assign win_valid = (state_q == RUN) && (outst_q < CNT_BITS'(FIFO_DEPTH));
   assign win_hs    = win_valid && win_ready;
   assign pop       = out_valid && out_ready;
   // The kernel cannot stall: a token leaving the delay line is captured unconditionally.
   assign push      = tok_q[KERNEL_LATENCY-1];

   always_comb begin
      // NOTE: every _d gets its hold value first so no path through the case infers a latch.
      state_d    = state_q;
      oh_d       = oh_q;
      ow_d       = ow_q;
      row_d      = row_q;
      col_d      = col_q;
      outst_d    = outst_q;
      pend_d     = pend_q;
      push_cnt_d = push ? push_cnt_q + SEQ_BITS'(1) : push_cnt_q;
      last_idx_d = last_idx_q;
      cfg_err_d  = 1'b0;
      tok_d      = {tok_q[KERNEL_LATENCY-2:0], kernel_x_valid};

      case ({win_hs, pop})
         2'b10:   outst_d = outst_q + CNT_ONE;
         2'b01:   outst_d = outst_q - CNT_ONE;
         default: outst_d = outst_q;
      endcase

      case ({win_hs, kernel_x_valid})
         2'b10:   pend_d = pend_q + CNT_ONE;
         2'b01:   pend_d = pend_q - CNT_ONE;
         default: pend_d = pend_q;
      endcase

      case (state_q)
         IDLE: begin
            if (start) begin
               if (cfg_ok) begin
                  state_d    = RUN;
                  oh_d       = oh_new;
                  ow_d       = ow_new;
                  row_d      = '0;
                  col_d      = '0;
                  push_cnt_d = '0;
                  last_idx_d = SEQ_BITS'(oh_new) * SEQ_BITS'(ow_new) - SEQ_BITS'(1);
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (win_hs) begin
               if (col_q == ow_q - DIM_ONE) begin
                  col_d = '0;
                  if (row_q == oh_q - DIM_ONE) state_d = DRAIN;
                  else                         row_d   = row_q + DIM_ONE;
               end else begin
                  col_d = col_q + DIM_ONE;
               end
            end
         end
         DRAIN:   if (outst_q == '0) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         oh_q       <= '0;
         ow_q       <= '0;
         row_q      <= '0;
         col_q      <= '0;
         outst_q    <= '0;
         pend_q     <= '0;
         tok_q      <= '0;
         push_cnt_q <= '0;
         last_idx_q <= '0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         oh_q       <= oh_d;
         ow_q       <= ow_d;
         row_q      <= row_d;
         col_q      <= col_d;
         outst_q    <= outst_d;
         pend_q     <= pend_d;
         tok_q      <= tok_d;
         push_cnt_q <= push_cnt_d;
         last_idx_q <= last_idx_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   assign push_entry = '{last: (push_cnt_q == last_idx_q), data: kernel_y};

   conv2d_result_fifo u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .empty     (fifo_empty),
      .pop_data  (head_entry)
   );

   assign busy      = (state_q == RUN) || (state_q == DRAIN);
   assign done      = (state_q == DONE);
   assign cfg_err   = cfg_err_q;
   assign win_row   = row_q;
   assign win_col   = col_q;
   assign out_valid = !fifo_empty;
   assign out_data  = head_entry.data;
   assign out_last  = head_entry.last;

   // The fetcher may only present x for a window it has already accepted.
   no_orphan_kernel_x: assert property (@(posedge clock) disable iff (reset)
      kernel_x_valid |-> (pend_q != '0));

endmodule

// File: tb/tb_conv2d_ctrl.sv
// Directed bench for conv2d_ctrl with a behavioural fetcher (x two cycles after
// accept) and kernel (y five cycles after x).
module tb_conv2d_ctrl;
   import conv2d_ctrl_pkg::*;

   logic                    clock = 1'b0;
   logic                    reset = 1'b1;
   logic                    start = 1'b0;
   logic [DIM_BITS-1:0]     cfg_height = '0;
   logic [DIM_BITS-1:0]     cfg_width  = '0;
   logic                    win_ready = 1'b0;
   logic                    kernel_x_valid = 1'b0;
   logic signed [BIT_Y-1:0] kernel_y = '0;
   logic                    out_ready = 1'b0;
   logic                    busy, done, cfg_err, win_valid, out_valid, out_last;
   logic [DIM_BITS-1:0]     win_row, win_col;
   logic signed [BIT_Y-1:0] out_data;

   conv2d_ctrl dut (
      .clock(clock), .reset(reset), .start(start),
      .cfg_height(cfg_height), .cfg_width(cfg_width),
      .busy(busy), .done(done), .cfg_err(cfg_err),
      .win_valid(win_valid), .win_ready(win_ready),
      .win_row(win_row), .win_col(win_col),
      .kernel_x_valid(kernel_x_valid), .kernel_y(kernel_y),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last)
   );

   always #5 clock = ~clock;

   localparam int NCYC = 4096;
   localparam logic [BIT_Y-1:0] Y_IDLE = 19'h2AAAA;

   int pass_cnt = 0, total_cnt = 0, fail_cnt = 0;

   bit               kx_at [NCYC];
   bit               yv_at [NCYC];
   logic [BIT_Y-1:0] y_at  [NCYC];
   int  cyc = 0, kx_idx = 0, outst = 0, max_outst = 0, both_cnt = 0;
   int  done_cnt = 0, cfg_err_cnt = 0, stab_err = 0, first_kx = -1, first_ov = -1;
   int  wr_mode = 0;
   bit  or_val = 1'b0, start_pulse = 1'b0, prev_stall = 1'b0;
   logic [DIM_BITS-1:0] prev_row = '0, prev_col = '0;
   logic [2*DIM_BITS-1:0] hs_coord [$];
   logic [BIT_Y-1:0]      res_data [$];
   bit                    res_last [$];

   function automatic logic [BIT_Y-1:0] yval(input int i);
      yval = BIT_Y'(32'h40000 + i * 37 + 5);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs mid-cycle, then log what the coming edge will accept.
   task automatic step();
      @(negedge clock);
      cyc++;
      if (cyc > NCYC - 8) begin
         $display("FAIL cycle_budget: observed %0d expected below %0d", cyc, NCYC - 8);
         $fatal(1, "cycle budget exhausted");
      end
      start       = start_pulse;
      start_pulse = 1'b0;
      out_ready   = or_val;
      case (wr_mode)
         0:       win_ready = 1'b1;
         1:       win_ready = cyc[0];
         default: win_ready = 1'b0;
      endcase
      kernel_x_valid = kx_at[cyc];
      if (kx_at[cyc]) begin
         y_at[cyc + KERNEL_LATENCY]  = yval(kx_idx);
         yv_at[cyc + KERNEL_LATENCY] = 1'b1;
         kx_idx++;
         if (first_kx < 0) first_kx = cyc;
      end
      kernel_y = yv_at[cyc] ? y_at[cyc] : Y_IDLE;
      #1;
      if (win_valid && win_ready) begin
         hs_coord.push_back({win_row, win_col});
         kx_at[cyc + 2] = 1'b1;
         outst++;
      end
      if (out_valid && out_ready) begin
         res_data.push_back(out_data);
         res_last.push_back(out_last);
         outst--;
      end
      if (win_valid && win_ready && out_valid && out_ready) both_cnt++;
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (outst > max_outst) max_outst = outst;
      if (done) done_cnt++;
      if (cfg_err) cfg_err_cnt++;
      if (prev_stall && win_valid && ({win_row, win_col} != {prev_row, prev_col})) stab_err++;
      prev_stall = win_valid && !win_ready;
      prev_row   = win_row;
      prev_col   = win_col;
   endtask

   task automatic begin_map(input int h, input int w);
      cfg_height  = DIM_BITS'(h);
      cfg_width   = DIM_BITS'(w);
      start_pulse = 1'b1;
      hs_coord.delete();
      res_data.delete();
      res_last.delete();
      kx_idx = 0; first_kx = -1; first_ov = -1; max_outst = 0; both_cnt = 0;
   endtask

   task automatic run_until_done(input string tag, input int bound);
      int d0, n;
      d0 = done_cnt;
      n  = 0;
      while (done_cnt == d0 && n < bound) begin
         step();
         n++;
      end
      check({tag, "_done_seen"}, done_cnt - d0, 1);
      step();
      check({tag, "_idle_after"}, {30'd0, busy, done}, 0);
      check({tag, "_single_done"}, done_cnt - d0, 1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctrl"}, {26'd0, busy, done, cfg_err, win_valid, out_valid, out_last}, 0);
      check({tag, "_coord"}, {16'd0, win_row, win_col}, 0);
      check({tag, "_data"}, {13'd0, out_data}, 0);
   endtask

   initial begin
      int bad, lasts, n;
      logic [3:0] last_mask;

      // Reset state
      repeat (2) @(negedge clock);
      check_all_zero("reset");
      reset = 1'b0;

      // Illegal configuration 2x5
      begin_map(2, 5);
      step();
      step();
      check("cfg_err_pulse", {29'd0, cfg_err, busy, win_valid}, 32'b100);
      step();
      check("cfg_err_clears", {29'd0, cfg_err, busy, win_valid}, 0);
      repeat (3) step();
      check("cfg_err_count", cfg_err_cnt, 1);
      check("cfg_err_no_window", hs_coord.size(), 0);

      // 4x4 map, fetcher accepts every other cycle, consumer always ready
      wr_mode = 1;
      or_val  = 1'b1;
      begin_map(4, 4);
      run_until_done("m44", 200);
      check("m44_hs_count", hs_coord.size(), 4);
      if (hs_coord.size() == 4) begin
         check("m44_coord0", {16'd0, hs_coord[0]}, 32'h0000);
         check("m44_coord1", {16'd0, hs_coord[1]}, 32'h0001);
         check("m44_coord2", {16'd0, hs_coord[2]}, 32'h0100);
         check("m44_coord3", {16'd0, hs_coord[3]}, 32'h0101);
      end
      check("m44_stall_stable", stab_err, 0);
      check("m44_res_count", res_data.size(), 4);
      if (res_data.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            check($sformatf("m44_data%0d", i), {13'd0, res_data[i]}, {13'd0, yval(i)});
            last_mask[i] = res_last[i];
         end
         check("m44_last_mask", {28'd0, last_mask}, 32'b1000);
      end

      // 3x3 map: single window, latency from x to first out_valid
      wr_mode = 0;
      begin_map(3, 3);
      run_until_done("m33", 100);
      check("m33_latency", first_ov - first_kx, KERNEL_LATENCY + 1);
      check("m33_res_count", res_data.size(), 1);
      if (res_data.size() == 1) begin
         check("m33_data", {13'd0, res_data[0]}, {13'd0, yval(0)});
         check("m33_last", {31'd0, res_last[0]}, 1);
      end

      // 8x8 map with consumer blocked: credits stop requests after FIFO_DEPTH
      or_val = 1'b0;
      begin_map(8, 8);
      repeat (40) step();
      check("m88_hs_blocked", hs_coord.size(), FIFO_DEPTH);
      check("m88_blocked_flags", {29'd0, busy, win_valid, out_valid}, 32'b101);
      check("m88_no_pop", res_data.size(), 0);
      or_val = 1'b1;
      run_until_done("m88", 400);
      check("m88_hs_total", hs_coord.size(), 36);
      check("m88_res_count", res_data.size(), 36);
      bad = 0;
      lasts = 0;
      for (int i = 0; i < res_data.size(); i++) begin
         if (res_data[i] !== yval(i)) bad++;
         if (res_last[i]) lasts++;
      end
      check("m88_data_order", bad, 0);
      check("m88_last_count", lasts, 1);
      if (res_last.size() == 36) check("m88_last_pos", {31'd0, res_last[35]}, 1);
      check("m88_max_outstanding", max_outst, FIFO_DEPTH);
      check("m88_pop_and_hs_same_cycle", {31'd0, both_cnt != 0}, 1);

      // Reset in the middle of a 4x4 run after three results
      begin_map(4, 4);
      n = 0;
      while (res_data.size() < 3 && n < 100) begin
         step();
         n++;
      end
      check("mid_three_results", res_data.size(), 3);
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < NCYC; i++) begin
         kx_at[i] = 1'b0;
         yv_at[i] = 1'b0;
      end
      outst = 0;
      prev_stall = 1'b0;
      #1;
      check_all_zero("mid_reset_async");
      @(negedge clock);
      #1;
      check_all_zero("mid_reset_next");
      reset = 1'b0;

      // Fresh 3x3 after the aborted run
      begin_map(3, 3);
      run_until_done("post", 100);
      check("post_res_count", res_data.size(), 1);
      if (res_data.size() == 1) begin
         check("post_data", {13'd0, res_data[0]}, {13'd0, yval(0)});
         check("post_last", {31'd0, res_last[0]}, 1);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
